// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour type and default palette for vga_scanout.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam bit SYNC_ACTIVE_LOW = 1'b1;
  localparam int FB_ADDR_W = 19;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Index 0 is the leftmost element.
  localparam rgb12_t [0:15] DEFAULT_PALETTE = {
    12'h000, 12'h800, 12'h080, 12'h00F,
    12'h880, 12'h808, 12'h088, 12'h888,
    12'h444, 12'hF00, 12'h0F0, 12'hFF0,
    12'hF80, 12'hF0F, 12'h0FF, 12'hFFF
  };

endpackage

// File: rtl/vga_timing.sv
// VGA raster counters: visible/sync flags for the current pixel and a frame_start
// pulse delayed to line up with the RGB output of pixel (0,0).
module vga_timing #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic clock,
  input  logic reset,
  input  logic pix_ce,
  output logic visible,
  output logic hs_on,
  output logic vs_on,
  output logic at_wrap,
  output logic at_last_vis,
  output logic frame_start
);
  import vga_pkg::*;

  localparam int LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic [9:0] hcnt_reg;
  logic [9:0] vcnt_reg;
  logic       origin_s1_reg;
  logic       frame_start_reg;
  logic       h_end;
  logic       v_end;
  logic       origin;

  assign h_end  = (hcnt_reg == 10'(LINE_LEN - 1));
  assign v_end  = (vcnt_reg == 10'(FRAME_LINES - 1));
  assign origin = (hcnt_reg == 10'd0) && (vcnt_reg == 10'd0);

  assign visible     = (hcnt_reg < 10'(H_VISIBLE)) && (vcnt_reg < 10'(V_VISIBLE));
  assign hs_on       = (hcnt_reg >= 10'(H_VISIBLE + H_FRONT)) &&
                       (hcnt_reg <  10'(H_VISIBLE + H_FRONT + H_SYNC));
  assign vs_on       = (vcnt_reg >= 10'(V_VISIBLE + V_FRONT)) &&
                       (vcnt_reg <  10'(V_VISIBLE + V_FRONT + V_SYNC));
  assign at_wrap     = h_end && v_end;
  assign at_last_vis = (hcnt_reg == 10'(H_VISIBLE - 1)) && (vcnt_reg == 10'(V_VISIBLE - 1));
  assign frame_start = frame_start_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      hcnt_reg        <= '0;
      vcnt_reg        <= '0;
      origin_s1_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      // One clock wide even when pix_ce is sparse.
      frame_start_reg <= pix_ce & origin_s1_reg;
      if (pix_ce) begin
        origin_s1_reg <= origin;
        if (h_end) begin
          hcnt_reg <= '0;
          vcnt_reg <= v_end ? 10'd0 : vcnt_reg + 10'd1;
        end else begin
          hcnt_reg <= hcnt_reg + 10'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: linear framebuffer address generation, 2-tick pixel pipeline and palette.
// Define VGA_SCANOUT_PALETTE_WRITE_EN for a run-time writable palette (pal_we/pal_idx/pal_rgb).
module vga_scanout #(
  parameter int H_VISIBLE       = vga_pkg::H_VISIBLE,
  parameter int H_FRONT         = vga_pkg::H_FRONT,
  parameter int H_SYNC          = vga_pkg::H_SYNC,
  parameter int H_BACK          = vga_pkg::H_BACK,
  parameter int V_VISIBLE       = vga_pkg::V_VISIBLE,
  parameter int V_FRONT         = vga_pkg::V_FRONT,
  parameter int V_SYNC          = vga_pkg::V_SYNC,
  parameter int V_BACK          = vga_pkg::V_BACK,
  parameter bit SYNC_ACTIVE_LOW = vga_pkg::SYNC_ACTIVE_LOW
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pix_ce,
  output logic [vga_pkg::FB_ADDR_W-1:0] addr_vga,
  input  logic [3:0]                    data_vga,
  output logic                          hsync,
  output logic                          vsync,
  output logic [3:0]                    vga_r,
  output logic [3:0]                    vga_g,
  output logic [3:0]                    vga_b,
  output logic                          active,
  output logic                          frame_start
`ifdef VGA_SCANOUT_PALETTE_WRITE_EN
  ,
  input  logic                          pal_we,
  input  logic [3:0]                    pal_idx,
  input  logic [11:0]                   pal_rgb
`endif
);
  import vga_pkg::*;

  logic visible, hs_on, vs_on, at_wrap, at_last_vis;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clock       (clock),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .visible     (visible),
    .hs_on       (hs_on),
    .vs_on       (vs_on),
    .at_wrap     (at_wrap),
    .at_last_vis (at_last_vis),
    .frame_start (frame_start)
  );

  logic [FB_ADDR_W-1:0] pix_addr_reg;
  logic                 vis_s1_reg, hs_s1_reg, vs_s1_reg;
  logic                 ce_d_reg;
  logic [3:0]           data_hold_reg;
  logic [3:0]           pal_lookup_idx;
  rgb12_t               pal_lookup;
  rgb12_t               rgb_reg;
  logic                 active_reg, hs_reg, vs_reg;

  assign addr_vga = pix_addr_reg;

  // Address never passes the last visible pixel; it holds there until the frame wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_addr_reg <= '0;
    end else if (pix_ce) begin
      if (at_wrap)
        pix_addr_reg <= '0;
      else if (visible && !at_last_vis)
        pix_addr_reg <= pix_addr_reg + FB_ADDR_W'(1);
    end
  end

  // The read data for the S0 address settles one clock after the S1 tick at the latest.
  // It is captured there, and bypassed when S2 lands on that very clock (pix_ce tied high).
  always_ff @(posedge clock) begin
    if (reset) begin
      vis_s1_reg    <= 1'b0;
      hs_s1_reg     <= 1'b0;
      vs_s1_reg     <= 1'b0;
      ce_d_reg      <= 1'b0;
      data_hold_reg <= '0;
    end else begin
      ce_d_reg <= pix_ce;
      if (ce_d_reg)
        data_hold_reg <= data_vga;
      if (pix_ce) begin
        vis_s1_reg <= visible;
        hs_s1_reg  <= hs_on;
        vs_s1_reg  <= vs_on;
      end
    end
  end

  assign pal_lookup_idx = ce_d_reg ? data_vga : data_hold_reg;

`ifdef VGA_SCANOUT_PALETTE_WRITE_EN
  rgb12_t pal_reg [16];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        pal_reg[i] <= DEFAULT_PALETTE[i];
    end else if (pal_we) begin
      pal_reg[pal_idx] <= rgb12_t'(pal_rgb);
    end
  end

  assign pal_lookup = pal_reg[pal_lookup_idx];
`else
  assign pal_lookup = DEFAULT_PALETTE[pal_lookup_idx];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rgb_reg    <= '0;
      active_reg <= 1'b0;
      hs_reg     <= 1'b0;
      vs_reg     <= 1'b0;
    end else if (pix_ce) begin
      rgb_reg    <= vis_s1_reg ? pal_lookup : rgb12_t'(12'h000);
      active_reg <= vis_s1_reg;
      hs_reg     <= hs_s1_reg;
      vs_reg     <= vs_s1_reg;
    end
  end

  assign vga_r  = rgb_reg.r;
  assign vga_g  = rgb_reg.g;
  assign vga_b  = rgb_reg.b;
  assign active = active_reg;
  assign hsync  = SYNC_ACTIVE_LOW ? ~hs_reg : hs_reg;
  assign vsync  = SYNC_ACTIVE_LOW ? ~vs_reg : vs_reg;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced raster so several whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_scanout;

  localparam int HV = 40, HF = 4, HS = 8, HB = 6;
  localparam int VV = 30, VF = 3, VS = 2, VB = 5;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pix_ce = 1'b1;
  logic [18:0] addr_vga;
  logic [3:0]  data_vga = 4'd0;
  logic        hsync, vsync, active, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;
`ifdef VGA_SCANOUT_PALETTE_WRITE_EN
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = 4'd0;
  logic [11:0] pal_rgb = 12'h000;
`endif

  always #5 clock = ~clock;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .addr_vga    (addr_vga),
    .data_vga    (data_vga),
    .hsync       (hsync),
    .vsync       (vsync),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .active      (active),
    .frame_start (frame_start)
`ifdef VGA_SCANOUT_PALETTE_WRITE_EN
    ,
    .pal_we      (pal_we),
    .pal_idx     (pal_idx),
    .pal_rgb     (pal_rgb)
`endif
  );

  // Framebuffer model: mode 0 alternates 3/12 by address parity, mode 1 is random per address.
  int         mode = 0;
  logic [1:0] rnd_mem [2048];

  function automatic logic [3:0] fb_idx(input int a);
    if (mode == 0) return (a % 2 == 1) ? 4'd12 : 4'd3;
    case (rnd_mem[a % 2048])
      2'd0: return 4'd0;
      2'd1: return 4'd3;
      2'd2: return 4'd12;
      default: return 4'd15;
    endcase
  endfunction

  always @(posedge clock) data_vga <= fb_idx(int'(addr_vga));

  logic [11:0] pal_m [16];

  function automatic void pal_default();
    for (int i = 0; i < 16; i++) pal_m[i] = 12'h000;
    pal_m[0] = 12'h000; pal_m[3] = 12'h00F; pal_m[12] = 12'hF80; pal_m[15] = 12'hFFF;
  endfunction

  typedef struct packed {
    logic [18:0] addr;
    logic [11:0] rgb;
    logic        act;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  exp_t exp_q [$];
  exp_t last_e, mod_e, mon_e;
  int   j = 0;
  int   checks = 0, errors = 0, fail_prints = 0;
  int   fs_seen = 0, fs_exp = 0;

  // Next-visible-pixel address for raster position p.
  function automatic int addr_of(input int p);
    int f, h, v;
    f = p % FRAME; h = f % HT; v = f / HT;
    if (h < HV && v < VV) return v * HV + h;
    if (v < VV - 1) return (v + 1) * HV;
    return VV * HV - 1;
  endfunction

  function automatic exp_t pix_exp(input int p);
    exp_t e;
    int f, h, v;
    f = p % FRAME; h = f % HT; v = f / HT;
    e.act  = (h < HV) && (v < VV);
    e.hs   = !((h >= HV + HF) && (h < HV + HF + HS));
    e.vs   = !((v >= VV + VF) && (v < VV + VF + VS));
    e.rgb  = e.act ? pal_m[fb_idx(v * HV + h)] : 12'h000;
    e.addr = '0;
    e.fs   = 1'b0;
    return e;
  endfunction

  always @(posedge clock) begin : model
    if (reset) begin
      j = 0;
      pal_default();
      mod_e = '{addr: 19'd0, rgb: 12'h000, act: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
    end else if (pix_ce) begin
      if (j == 0) mod_e = '{addr: 19'd0, rgb: 12'h000, act: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
      else        mod_e = pix_exp(j - 1);
      mod_e.addr = 19'(addr_of(j + 1));
      mod_e.fs   = (j >= 1) && ((j - 1) % FRAME == 0);
      j++;
    end else begin
      mod_e = last_e;
      mod_e.fs = 1'b0;
    end
`ifdef VGA_SCANOUT_PALETTE_WRITE_EN
    if (!reset && pal_we) pal_m[pal_idx] = pal_rgb;
`endif
    if (mod_e.fs) fs_exp++;
    last_e = mod_e;
    exp_q.push_back(mod_e);
  end

  always @(negedge clock) begin : monitor
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (addr_vga !== mon_e.addr || {vga_r, vga_g, vga_b} !== mon_e.rgb ||
          active !== mon_e.act || hsync !== mon_e.hs || vsync !== mon_e.vs ||
          frame_start !== mon_e.fs) begin
        errors++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL pix_out t=%0t got addr=%0d rgb=%03h act=%0b hs=%0b vs=%0b fs=%0b exp addr=%0d rgb=%03h act=%0b hs=%0b vs=%0b fs=%0b",
                   $time, addr_vga, {vga_r, vga_g, vga_b}, active, hsync, vsync, frame_start,
                   mon_e.addr, mon_e.rgb, mon_e.act, mon_e.hs, mon_e.vs, mon_e.fs);
        end
      end
      if (frame_start) begin
        fs_seen++;
        $display("frame %0d start t=%0t rgb=%03h", fs_seen, $time, {vga_r, vga_g, vga_b});
      end
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Reset held with pix_ce high, then alternating data at full rate.
    pix_ce = 1'b1;
    mode = 0;
    do_reset(5);
    repeat (2 * FRAME + 20) @(negedge clock);

    // Same pattern with pix_ce one clock in four.
    do_reset(2);
    for (int c = 0; c < 4 * (FRAME + 100); c++) begin
      pix_ce = (c % 4 == 0);
      @(negedge clock);
    end

    // Random data, random pix_ce, occasional palette writes.
    mode = 1;
    for (int i = 0; i < 2048; i++) rnd_mem[i] = 2'($urandom_range(0, 3));
    do_reset(2);
    for (int c = 0; c < 2 * 2 * FRAME; c++) begin
      pix_ce = 1'($urandom_range(0, 1));
`ifdef VGA_SCANOUT_PALETTE_WRITE_EN
      pal_we = 1'b0;
      if (c == 500) begin
        pal_we = 1'b1; pal_idx = 4'd3; pal_rgb = 12'hABC;
      end else if ($urandom_range(0, 199) == 0) begin
        pal_we = 1'b1;
        case ($urandom_range(0, 3))
          0: pal_idx = 4'd0;
          1: pal_idx = 4'd3;
          2: pal_idx = 4'd12;
          default: pal_idx = 4'd15;
        endcase
        pal_rgb = 12'($urandom_range(0, 4095));
      end
`endif
      @(negedge clock);
    end
`ifdef VGA_SCANOUT_PALETTE_WRITE_EN
    pal_we = 1'b0;
`endif

    // Reset in the middle of a frame, then run on through another full frame.
    pix_ce = 1'b1;
    begin
      int guard;
      guard = 0;
      while (j % FRAME != 15 * HT + 20 && guard < 2 * FRAME) begin
        @(negedge clock);
        guard++;
      end
      checks++;
      if (guard >= 2 * FRAME) begin
        errors++;
        $display("FAIL midframe_wait got guard=%0d exp <%0d", guard, 2 * FRAME);
      end
    end
    do_reset(1);
    repeat (FRAME + 50) @(negedge clock);

    pix_ce = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (fs_seen != fs_exp) begin
      errors++;
      $display("FAIL frame_count got %0d exp %0d", fs_seen, fs_exp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
